// File: rtl/mem_port_arbiter_pkg.sv
// Shared types and constants for the IF/data RAM port arbiter.
// Holds the FSM states, owner/size encodings and the big-endian lane helper.
package mem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        XFER = 2'd1,
        DONE = 2'd2
    } state_t;

    typedef enum logic {
        OWN_IF = 1'b0,
        OWN_D  = 1'b1
    } owner_t;

    typedef enum logic {
        SIZE_BYTE = 1'b0,
        SIZE_WORD = 1'b1
    } size_t;

    localparam int BEATS_PER_WORD = 4;
    localparam int BEAT_W         = $clog2(BEATS_PER_WORD);

    // Beat 0 carries the most significant byte (big-endian word layout in RAM).
    function automatic logic [7:0] word_lane(input logic [31:0] word, input logic [BEAT_W-1:0] beat);
        return word[8*(BEATS_PER_WORD-1-int'(beat)) +: 8];
    endfunction

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Bundle of the fetch port, data port and byte-wide RAM port.
// The arbiter uses the slave modport; requesters and the RAM sit on the master side.
interface mem_port_arbiter_if #(
    parameter int ADDR_W = 8
);
    logic              if_req;
    logic [31:0]       if_addr;
    logic [31:0]       if_rdata;
    logic              if_ack;

    logic              d_req;
    logic              d_we;
    logic              d_size;
    logic [31:0]       d_addr;
    logic [31:0]       d_wdata;
    logic [31:0]       d_rdata;
    logic              d_ack;

    logic              mem_en;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [7:0]        mem_wdata;
    logic [7:0]        mem_rdata;

    modport slave (
        input  if_req, if_addr, d_req, d_we, d_size, d_addr, d_wdata, mem_rdata,
        output if_rdata, if_ack, d_rdata, d_ack, mem_en, mem_we, mem_addr, mem_wdata
    );

    modport master (
        output if_req, if_addr, d_req, d_we, d_size, d_addr, d_wdata, mem_rdata,
        input  if_rdata, if_ack, d_rdata, d_ack, mem_en, mem_we, mem_addr, mem_wdata
    );

endinterface

// File: rtl/mem_port_arbiter_byte_lane_assembler.sv
// Collects read bytes into a 32-bit shadow word, one big-endian lane per beat.
// o_word_next already contains the byte being captured this cycle.
module byte_lane_assembler
    import mem_arb_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic              i_capture,
    input  logic [BEAT_W-1:0] i_beat,
    input  logic [7:0]        i_byte,
    output logic [31:0]       o_word_next
);

    logic [31:0] r_shadow;

    always_comb begin
        o_word_next = r_shadow;
        for (int lane = 0; lane < BEATS_PER_WORD; lane++) begin
            if (i_capture && (i_beat == BEAT_W'(BEATS_PER_WORD - 1 - lane)))
                o_word_next[8*lane +: 8] = i_byte;
        end
    end

    // NOTE: the shadow is a plain register, so it is cleared on reset like all other state.
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            r_shadow <= '0;
        else if (i_capture)
            r_shadow <= o_word_next;
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one byte-wide RAM between instruction fetch and the load/store stage,
// serialising word accesses into four big-endian byte beats.
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W       = 8,
    parameter int STARVE_LIMIT = 2
)(
    input logic                clk,
    input logic                reset,
    mem_port_arbiter_if.slave  bus
);

    localparam int STARVE_W = $clog2(STARVE_LIMIT + 1);

    state_t               r_state;
    state_t               w_state_next;
    owner_t               r_owner;
    logic                 r_we;
    logic                 r_size_word;
    logic [ADDR_W-1:0]    r_base;
    logic [31:0]          r_wdata;
    logic [BEAT_W-1:0]    r_beat;
    logic [STARVE_W-1:0]  r_starve;
    logic [31:0]          r_if_rdata;
    logic [31:0]          r_d_rdata;

    logic                 w_grant;
    logic                 w_grant_if;
    logic                 w_grant_d;
    logic                 w_xfer;
    logic                 w_last;
    logic [31:0]          w_word_next;
    logic                 w_unused_addr;

    // Data has priority until IF has been passed over STARVE_LIMIT times in a row.
    assign w_grant    = (r_state == IDLE) && (bus.if_req || bus.d_req);
    assign w_grant_if = w_grant && bus.if_req &&
                        ((r_starve == STARVE_W'(STARVE_LIMIT)) || !bus.d_req);
    assign w_grant_d  = w_grant && !w_grant_if;
    assign w_xfer     = (r_state == XFER);
    assign w_last     = (r_beat == (r_size_word ? BEAT_W'(BEATS_PER_WORD - 1) : '0));

    assign w_unused_addr = ^{bus.if_addr[31:ADDR_W], bus.d_addr[31:ADDR_W]};

    byte_lane_assembler u_assembler (
        .clk         (clk),
        .reset       (reset),
        .i_capture   (w_xfer && !r_we),
        .i_beat      (r_beat),
        .i_byte      (bus.mem_rdata),
        .o_word_next (w_word_next)
    );

    // NOTE: every output of this block gets a default first, so no latches are inferred.
    always_comb begin
        w_state_next  = r_state;
        bus.mem_en    = 1'b0;
        bus.mem_we    = 1'b0;
        bus.mem_addr  = '0;
        bus.mem_wdata = '0;
        bus.if_ack    = 1'b0;
        bus.d_ack     = 1'b0;
        unique case (r_state)
            IDLE: if (w_grant) w_state_next = XFER;
            XFER: begin
                bus.mem_en   = 1'b1;
                bus.mem_we   = r_we;
                bus.mem_addr = r_base + ADDR_W'(r_beat);
                if (r_we)
                    bus.mem_wdata = r_size_word ? word_lane(r_wdata, r_beat) : r_wdata[7:0];
                if (w_last) w_state_next = DONE;
            end
            DONE: begin
                bus.if_ack   = (r_owner == OWN_IF);
                bus.d_ack    = (r_owner == OWN_D);
                w_state_next = IDLE;
            end
            default: w_state_next = IDLE;
        endcase
    end

    assign bus.if_rdata = r_if_rdata;
    assign bus.d_rdata  = r_d_rdata;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state     <= IDLE;
            r_owner     <= OWN_IF;
            r_we        <= 1'b0;
            r_size_word <= 1'b0;
            r_base      <= '0;
            r_wdata     <= '0;
            r_beat      <= '0;
            r_starve    <= '0;
            r_if_rdata  <= '0;
            r_d_rdata   <= '0;
        end else begin
            r_state <= w_state_next;

            if (w_grant) begin
                r_owner     <= w_grant_if ? OWN_IF : OWN_D;
                r_base      <= w_grant_if ? bus.if_addr[ADDR_W-1:0] : bus.d_addr[ADDR_W-1:0];
                r_we        <= w_grant_d && bus.d_we;
                r_size_word <= w_grant_if || (bus.d_size == SIZE_WORD);
                r_wdata     <= bus.d_wdata;
                r_beat      <= '0;
            end else if (w_xfer) begin
                r_beat <= r_beat + 1'b1;
            end

            if (!bus.if_req || w_grant_if)
                r_starve <= '0;
            else if (w_grant_d)
                r_starve <= r_starve + 1'b1;

            // Results land on the last beat edge so they are valid throughout the ack cycle.
            if (w_xfer && w_last && !r_we) begin
                if (r_owner == OWN_IF)
                    r_if_rdata <= w_word_next;
                else
                    r_d_rdata <= r_size_word ? w_word_next : {24'h0, w_word_next[31:24]};
            end
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: directed vector table, arbitration and reset
// sequences, then randomized traffic on both ports against a byte-array reference model.
module tb_mem_port_arbiter;
    import mem_arb_pkg::*;

    localparam int ADDR_W = 8;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    mem_port_arbiter_if #(.ADDR_W(ADDR_W)) bus ();

    mem_port_arbiter #(.ADDR_W(ADDR_W), .STARVE_LIMIT(2)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Byte-wide RAM model; pokes let the bench preload it without touching the arbiter.
    logic [7:0] ram [256];
    logic       poke_en = 1'b0;
    logic [7:0] poke_addr = 8'h00;
    logic [7:0] poke_data = 8'h00;

    always @(posedge clk) begin
        if (poke_en)
            ram[poke_addr] <= poke_data;
        else if (bus.mem_en && bus.mem_we)
            ram[bus.mem_addr] <= bus.mem_wdata;
    end
    assign bus.mem_rdata = bus.mem_en ? ram[bus.mem_addr] : 8'h00;

    task automatic poke(input logic [7:0] a, input logic [7:0] d);
        @(negedge clk);
        poke_en = 1'b1; poke_addr = a; poke_data = d;
        @(posedge clk);
        #1 poke_en = 1'b0;
    endtask

    // Beat monitor for the directed vectors.
    typedef struct packed { logic we; logic [7:0] addr; logic [7:0] wdata; } beat_t;
    beat_t beats [$];
    always @(negedge clk) if (bus.mem_en) beats.push_back({bus.mem_we, bus.mem_addr, bus.mem_wdata});

    typedef struct {
        bit          is_if;
        bit          we;
        bit          size;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] exp_rdata;
    } vec_t;

    vec_t vecs [11];

    // Issues one transaction starting at a negedge in IDLE; returns rdata and edges-to-ack.
    task automatic xact(input vec_t v, output logic [31:0] rdata, output int lat);
        bit got = 1'b0;
        beats.delete();
        lat = 0;
        if (v.is_if) begin
            bus.if_addr = v.addr; bus.if_req = 1'b1;
        end else begin
            bus.d_we = v.we; bus.d_size = v.size; bus.d_addr = v.addr; bus.d_wdata = v.wdata;
            bus.d_req = 1'b1;
        end
        for (int t = 0; t < 50 && !got; t++) begin
            @(negedge clk);
            lat++;
            got = v.is_if ? bus.if_ack : bus.d_ack;
        end
        rdata = v.is_if ? bus.if_rdata : bus.d_rdata;
        if (!got) check("ack_timeout", 32'd0, 32'd1);
        bus.if_req = 1'b0;
        bus.d_req  = 1'b0;
        @(negedge clk);
    endtask

    task automatic check_outputs_zero(input string pfx);
        check({pfx, "_mem_en"},    32'(bus.mem_en),    32'd0);
        check({pfx, "_mem_we"},    32'(bus.mem_we),    32'd0);
        check({pfx, "_mem_addr"},  32'(bus.mem_addr),  32'd0);
        check({pfx, "_mem_wdata"}, 32'(bus.mem_wdata), 32'd0);
        check({pfx, "_acks"},      32'({bus.if_ack, bus.d_ack}), 32'd0);
        check({pfx, "_if_rdata"},  bus.if_rdata, 32'd0);
        check({pfx, "_d_rdata"},   bus.d_rdata,  32'd0);
    endtask

    // Reference model: flat byte image plus the last load result seen on d_rdata.
    logic [7:0]  ref_mem [256];
    logic [31:0] last_load;

    function automatic logic [31:0] ref_word(input logic [31:0] addr);
        logic [31:0] w = 32'h0;
        for (int i = 0; i < 4; i++) w = {w[23:0], ref_mem[addr[7:0] + 8'(i)]};
        return w;
    endfunction

    initial begin
        #500_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] rdata;
        int          lat;
        int          nb;
        int          n_acks;
        int          cyc;
        int          order [6];
        int          ack_cyc [6];
        int          exp_order [6];
        int          bad;

        reset = 1'b1;
        bus.if_req = 1'b0; bus.if_addr = '0;
        bus.d_req = 1'b0; bus.d_we = 1'b0; bus.d_size = 1'b0; bus.d_addr = '0; bus.d_wdata = '0;

        repeat (2) @(negedge clk);
        check_outputs_zero("reset");
        reset = 1'b0;

        poke(8'h00, 8'h11); poke(8'h01, 8'h22); poke(8'h02, 8'h33); poke(8'h03, 8'h44);
        @(negedge clk);

        // Directed vectors: exp_rdata is the owner's rdata after ack (stores leave d_rdata alone).
        vecs[0]  = '{1'b1, 1'b0, 1'b1, 32'h0000_0000, 32'h0,         32'h1122_3344};
        vecs[1]  = '{1'b0, 1'b1, 1'b1, 32'h0000_0010, 32'hDEAD_BEEF, 32'h0000_0000};
        vecs[2]  = '{1'b0, 1'b0, 1'b0, 32'h0000_0012, 32'h0,         32'h0000_00BE};
        vecs[3]  = '{1'b0, 1'b0, 1'b1, 32'h0000_0010, 32'h0,         32'hDEAD_BEEF};
        vecs[4]  = '{1'b0, 1'b1, 1'b0, 32'h0000_0011, 32'hFFFF_FF5A, 32'hDEAD_BEEF};
        vecs[5]  = '{1'b0, 1'b0, 1'b1, 32'h0000_0010, 32'h0,         32'hDE5A_BEEF};
        vecs[6]  = '{1'b0, 1'b1, 1'b1, 32'h0000_00FE, 32'hA1A2_A3A4, 32'hDE5A_BEEF};
        vecs[7]  = '{1'b1, 1'b0, 1'b1, 32'h0000_00FE, 32'h0,         32'hA1A2_A3A4};
        vecs[8]  = '{1'b1, 1'b0, 1'b1, 32'h0000_0000, 32'h0,         32'hA3A4_3344};
        vecs[9]  = '{1'b0, 1'b0, 1'b0, 32'h3000_00FF, 32'h0,         32'h0000_00A2};
        vecs[10] = '{1'b1, 1'b0, 1'b1, 32'hABCD_EF10, 32'h0,         32'hDE5A_BEEF};

        for (int k = 0; k < 11; k++) begin
            xact(vecs[k], rdata, lat);
            nb = (vecs[k].is_if || vecs[k].size) ? 4 : 1;
            check($sformatf("v%0d_rdata", k), rdata, vecs[k].exp_rdata);
            check($sformatf("v%0d_latency", k), 32'(lat), 32'(nb + 1));
            check($sformatf("v%0d_nbeats", k), 32'(beats.size()), 32'(nb));
            for (int i = 0; i < nb && i < beats.size(); i++) begin
                logic [7:0] ea;
                logic [7:0] ew;
                ea = vecs[k].addr[7:0] + 8'(i);
                if (!vecs[k].we)       ew = 8'h00;
                else if (vecs[k].size) ew = 8'(vecs[k].wdata >> (8 * (3 - i)));
                else                   ew = vecs[k].wdata[7:0];
                check($sformatf("v%0d_beat%0d", k, i), 32'(beats[i]), 32'({vecs[k].we, ea, ew}));
            end
        end

        // Both requesters held high: D,D,IF repeating, one word every 6 cycles.
        exp_order = '{0, 0, 1, 0, 0, 1};
        bus.if_addr = 32'h0; bus.d_we = 1'b0; bus.d_size = 1'b1; bus.d_addr = 32'h10;
        bus.if_req = 1'b1; bus.d_req = 1'b1;
        n_acks = 0; cyc = 0;
        while (n_acks < 6 && cyc < 100) begin
            @(negedge clk);
            cyc++;
            if (bus.if_ack || bus.d_ack) begin
                order[n_acks]   = bus.if_ack ? 1 : 0;
                ack_cyc[n_acks] = cyc;
                if (bus.if_ack) check("arb_if_data", bus.if_rdata, 32'hA3A4_3344);
                else            check("arb_d_data",  bus.d_rdata,  32'hDE5A_BEEF);
                n_acks++;
            end
        end
        bus.if_req = 1'b0; bus.d_req = 1'b0;
        @(negedge clk);
        check("arb_ack_count", 32'(n_acks), 32'd6);
        check("arb_first_ack", 32'(ack_cyc[0]), 32'd5);
        for (int i = 0; i < n_acks; i++) begin
            check($sformatf("arb_order%0d", i), 32'(order[i]), 32'(exp_order[i]));
            if (i > 0) check($sformatf("arb_spacing%0d", i), 32'(ack_cyc[i] - ack_cyc[i-1]), 32'd6);
        end

        // Reset during beat 2 of a word store: beats 0 and 1 stay written, no ack.
        poke(8'h20, 8'h00); poke(8'h21, 8'h00); poke(8'h22, 8'h00); poke(8'h23, 8'h00);
        @(negedge clk);
        bus.d_we = 1'b1; bus.d_size = 1'b1; bus.d_addr = 32'h20; bus.d_wdata = 32'h0102_0304;
        bus.d_req = 1'b1;
        repeat (3) @(negedge clk);
        check("rst_pre_addr", 32'(bus.mem_addr), 32'h22);
        reset = 1'b1;
        bus.d_req = 1'b0;
        #1;
        check_outputs_zero("midrst");
        repeat (2) @(negedge clk);
        reset = 1'b0;
        n_acks = 0;
        repeat (6) begin
            @(negedge clk);
            if (bus.d_ack || bus.if_ack) n_acks++;
        end
        check("rst_no_ack", 32'(n_acks), 32'd0);
        check("rst_partial", {ram[8'h20], ram[8'h21], ram[8'h22], ram[8'h23]}, 32'h0102_0000);
        xact('{1'b1, 1'b0, 1'b1, 32'h20, 32'h0, 32'h0}, rdata, lat);
        check("rst_after_rdata", rdata, 32'h0102_0000);
        check("rst_after_latency", 32'(lat), 32'd5);

        // Randomized traffic on both ports against the reference model.
        for (int i = 0; i < 256; i++) begin
            logic [7:0] b;
            b = 8'($urandom);
            ref_mem[i] = b;
            poke(8'(i), b);
        end
        @(negedge clk);
        last_load = 32'h0;

        fork
            begin : if_traffic
                logic [31:0] a;
                bit          got;
                for (int n = 0; n < 40; n++) begin
                    repeat ($urandom_range(1, 3)) @(negedge clk);
                    a = $urandom;
                    bus.if_addr = a;
                    bus.if_req  = 1'b1;
                    got = 1'b0;
                    for (int t = 0; t < 100 && !got; t++) begin
                        @(negedge clk);
                        got = bus.if_ack;
                    end
                    if (!got) check("rnd_if_timeout", 32'd0, 32'd1);
                    else      check("rnd_if_rdata", bus.if_rdata, ref_word(a));
                    bus.if_req = 1'b0;
                end
            end
            begin : d_traffic
                logic [31:0] a;
                logic [31:0] wd;
                logic [31:0] exp;
                bit          we;
                bit          sz;
                bit          got;
                for (int n = 0; n < 40; n++) begin
                    repeat ($urandom_range(1, 3)) @(negedge clk);
                    we = 1'($urandom_range(0, 1));
                    sz = 1'($urandom_range(0, 1));
                    a  = $urandom;
                    wd = $urandom;
                    bus.d_we = we; bus.d_size = sz; bus.d_addr = a; bus.d_wdata = wd;
                    bus.d_req = 1'b1;
                    got = 1'b0;
                    for (int t = 0; t < 100 && !got; t++) begin
                        @(negedge clk);
                        got = bus.d_ack;
                    end
                    if (!got) begin
                        check("rnd_d_timeout", 32'd0, 32'd1);
                    end else if (we) begin
                        if (sz) for (int i = 0; i < 4; i++) ref_mem[a[7:0] + 8'(i)] = wd[8*(3-i) +: 8];
                        else    ref_mem[a[7:0]] = wd[7:0];
                        check("rnd_d_store_keeps_rdata", bus.d_rdata, last_load);
                    end else begin
                        exp = sz ? ref_word(a) : {24'h0, ref_mem[a[7:0]]};
                        check("rnd_d_load", bus.d_rdata, exp);
                        last_load = exp;
                    end
                    bus.d_req = 1'b0;
                end
            end
        join

        repeat (3) @(negedge clk);
        bad = 0;
        for (int i = 0; i < 256; i++) if (ram[i] !== ref_mem[i]) bad++;
        check("rnd_ram_image", 32'(bad), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
